// File: rtl/demux_stream_if.sv
// Stream bus for demux_stream: one upstream port, two downstream channels and
// the per-channel delivered-word counters.
interface demux_stream_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;

  logic [3:0]       cnt0;
  logic [3:0]       cnt1;

  // Producer/consumer side: drives upstream words and downstream readies.
  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );

  // Block side.
  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );
endinterface

// File: rtl/demux_stream.sv
// Two-way stream demultiplexer: each channel is a one-word skid-free holding
// register with a full flag, plus a mod-16 count of words delivered downstream.
module demux_stream #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  demux_stream_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  chan_state_e      state_q [2];
  chan_state_e      state_d [2];
  logic [WIDTH-1:0] data_q  [2];
  logic [WIDTH-1:0] data_d  [2];
  logic [3:0]       cnt_q   [2];
  logic [3:0]       cnt_d   [2];

  logic [1:0] out_ready;
  logic [1:0] load;
  logic [1:0] drain;
  logic       in_ready;
  logic       up_xfer;

  // in_ready looks only at the selected channel, never at in_valid, so a
  // full channel that is being drained this cycle can be refilled in place.
  always_comb begin
    out_ready = {bus.out1_ready, bus.out0_ready};
    in_ready  = (state_q[bus.in_sel] == EMPTY) || out_ready[bus.in_sel];
    up_xfer   = bus.in_valid && in_ready;
    load      = '0;
    drain     = '0;

    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      data_d[ch]  = data_q[ch];

      drain[ch] = (state_q[ch] == FULL) && out_ready[ch];
      load[ch]  = up_xfer && (int'(bus.in_sel) == ch);

      case (state_q[ch])
        EMPTY: if (load[ch]) state_d[ch] = FULL;
        FULL: begin
          if (load[ch])       state_d[ch] = FULL;
          else if (drain[ch]) state_d[ch] = EMPTY;
        end
      endcase

      if (load[ch]) data_d[ch] = bus.in_data;
      cnt_d[ch] = cnt_q[ch] + {3'b000, drain[ch]};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the holding registers are cleared too, not just the full flags,
      // because the data outputs must read 0 straight after reset.
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= EMPTY;
        data_q[ch]  <= '0;
        cnt_q[ch]   <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        data_q[ch]  <= data_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out0_valid = (state_q[0] == FULL);
  assign bus.out0_data  = data_q[0];
  assign bus.out1_valid = (state_q[1] == FULL);
  assign bus.out1_data  = data_q[1];
  assign bus.cnt0       = cnt_q[0];
  assign bus.cnt1       = cnt_q[1];

endmodule

// File: tb/tb_demux_stream.sv
// Scoreboard bench for demux_stream: each channel is modelled as a queue of
// accepted-but-undelivered words plus a running delivered-word total.
module tb_demux_stream;
  localparam int W = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  demux_stream_if #(.WIDTH(W)) bus ();

  demux_stream #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit done        = 1'b0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int           delivered0 = 0;
  int           delivered1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q0.delete();
    exp_q1.delete();
    delivered0 = 0;
    delivered1 = 0;
  endtask

  // Output monitor, posedge+3: compare channel outputs with the model, then
  // retire any word the consumer takes at the coming edge.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (!done) begin
        check("out0_valid", 32'(bus.out0_valid), 32'(exp_q0.size() != 0));
        if (exp_q0.size() != 0) check("out0_data", 32'(bus.out0_data), 32'(exp_q0[0]));
        check("cnt0", 32'(bus.cnt0), 32'(delivered0 % 16));
        check("out1_valid", 32'(bus.out1_valid), 32'(exp_q1.size() != 0));
        if (exp_q1.size() != 0) check("out1_data", 32'(bus.out1_data), 32'(exp_q1[0]));
        check("cnt1", 32'(bus.cnt1), 32'(delivered1 % 16));
        if (!reset) begin
          if (bus.out0_ready && exp_q0.size() != 0) begin
            void'(exp_q0.pop_front());
            delivered0++;
          end
          if (bus.out1_ready && exp_q1.size() != 0) begin
            void'(exp_q1.pop_front());
            delivered1++;
          end
        end
      end
    end
  end

  // Input monitor, posedge+5: a channel can take a word when it holds nothing
  // once this cycle's delivery is retired; accepted words join that queue.
  initial begin
    logic exp_ready;
    forever begin
      @(posedge clk);
      #5;
      if (!done && !reset) begin
        exp_ready = bus.in_sel ? (exp_q1.size() == 0) : (exp_q0.size() == 0);
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        if (bus.in_valid && bus.in_ready) begin
          if (bus.in_sel) exp_q1.push_back(bus.in_data);
          else            exp_q0.push_back(bus.in_data);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic s, input logic [W-1:0] d,
                       input logic r0, input logic r1);
    @(posedge clk);
    #1;
    bus.in_valid   = v;
    bus.in_sel     = s;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
  endtask

  // Holds reset for one edge with the given inputs applied, then idles.
  task automatic reset_with(input logic v, input logic s, input logic [W-1:0] d,
                            input logic r0, input logic r1);
    drive(v, s, d, r0, r1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b0;
    bus.in_data    = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    #1;
    check({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
    check({tag, "_out0_valid"}, 32'(bus.out0_valid), 32'd0);
    check({tag, "_out1_valid"}, 32'(bus.out1_valid), 32'd0);
    check({tag, "_out0_data"},  32'(bus.out0_data),  32'd0);
    check({tag, "_out1_data"},  32'(bus.out1_data),  32'd0);
    check({tag, "_cnt0"},       32'(bus.cnt0),       32'd0);
    check({tag, "_cnt1"},       32'(bus.cnt1),       32'd0);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b0;
    bus.in_data    = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;

    reset_with(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
    check_reset_state("por");

    // Single word into channel 0, consumer stalled.
    drive(1'b1, 1'b0, 4'b1010, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    #1;
    check("t30_out0_valid", 32'(bus.out0_valid), 32'd1);
    check("t30_out0_data",  32'(bus.out0_data),  32'hA);
    check("t30_out1_valid", 32'(bus.out1_valid), 32'd0);
    check("t30_cnt0",       32'(bus.cnt0),       32'd0);

    // Blocked channel 0 holds its word; channel 1 still accepts.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
      #1;
      check("t31_in_ready",  32'(bus.in_ready),  32'd0);
      check("t31_out0_data", 32'(bus.out0_data), 32'hA);
    end
    drive(1'b1, 1'b1, 4'b0101, 1'b0, 1'b0);
    #1;
    check("t31_in_ready_ch1", 32'(bus.in_ready), 32'd1);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    #1;
    check("t31_out1_valid", 32'(bus.out1_valid), 32'd1);
    check("t31_out1_data",  32'(bus.out1_data),  32'h5);

    // Both channels drain together.
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    #1;
    check("t33_out0_valid", 32'(bus.out0_valid), 32'd0);
    check("t33_out1_valid", 32'(bus.out1_valid), 32'd0);
    check("t33_cnt0",       32'(bus.cnt0),       32'd1);
    check("t33_cnt1",       32'(bus.cnt1),       32'd1);

    // Simultaneous drain and refill of channel 0.
    drive(1'b1, 1'b0, 4'b0001, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'b0010, 1'b1, 1'b0);
    #1;
    check("t32_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    #1;
    check("t32_out0_valid", 32'(bus.out0_valid), 32'd1);
    check("t32_out0_data",  32'(bus.out0_data),  32'h2);
    check("t32_cnt0",       32'(bus.cnt0),       32'd2);

    // 17 back-to-back channel-1 words: no stalls, counter wraps through 0.
    reset_with(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, 4'(i), 1'b0, 1'b1);
      #1;
      check("t34_in_ready", 32'(bus.in_ready), 32'd1);
      check("t34_cnt1", 32'(bus.cnt1), 32'((i == 0) ? 0 : (i - 1) % 16));
    end
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    #1;
    check("t34_cnt1_wrap", 32'(bus.cnt1), 32'd0);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    #1;
    check("t34_cnt1_final", 32'(bus.cnt1), 32'd1);

    // Reset wins over a same-cycle upstream transfer and drain.
    drive(1'b1, 1'b0, 4'h7, 1'b0, 1'b0);
    reset_with(1'b1, 1'b1, 4'h9, 1'b1, 1'b0);
    check_reset_state("t35");

    // Randomised traffic with occasional mid-stream resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_with(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        drive(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
      end
    end

    // Flush and confirm every accepted word was delivered.
    repeat (4) drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    @(posedge clk);
    #6;
    done = 1'b1;
    check("flush_q0_empty", 32'(exp_q0.size()), 32'd0);
    check("flush_q1_empty", 32'(exp_q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
